// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: arms the trigger FSM, counts its sample strobes into records and
// forwards them as addressed capture-buffer writes. Optional idle timeout under ACQ_TIMEOUT_EN.
module acq_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned TMO_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [23:0]       cfg_samples,
  input  logic [23:0]       cfg_reps,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic [1:0]        fsm_state,
  input  logic              fsm_we,
  input  logic [13:0]       fsm_data,
  output logic              sniff_trig,
  output logic [23:0]       max_sample_cnt,
  output logic [23:0]       max_repetition_cnt,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [13:0]       buf_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              timeout,
  output logic [23:0]       rec_cnt
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StFinish} state_e;

  localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic              start_q;
  logic [23:0]       smp_cnt_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              start_edge;
  logic              rec_last;

  assign start_edge = start & ~start_q;
  assign rec_last   = (rec_cnt + 24'd1) == max_repetition_cnt;

`ifdef ACQ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TmoOne = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_lim_q;
  logic             tmo_fire;

  // Fires on the cycle the idle count would reach the limit, so IDLE lands exactly
  // cfg_timeout cycles after RUN entry.
  assign tmo_fire = (state_q == StRun) && !fsm_we && (tmo_lim_q != '0) &&
                    ((tmo_cnt_q + TmoOne) == tmo_lim_q);
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      start_q            <= 1'b0;
      smp_cnt_q          <= '0;
      wr_ptr_q           <= '0;
      sniff_trig         <= 1'b0;
      max_sample_cnt     <= '0;
      max_repetition_cnt <= '0;
      buf_we             <= 1'b0;
      buf_addr           <= '0;
      buf_data           <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      overflow           <= 1'b0;
      rec_cnt            <= '0;
`ifdef ACQ_TIMEOUT_EN
      timeout            <= 1'b0;
      tmo_cnt_q          <= '0;
      tmo_lim_q          <= '0;
`endif
    end else begin
      start_q    <= start;
      sniff_trig <= 1'b0;
      buf_we     <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_edge) begin
              max_sample_cnt     <= cfg_samples;
              max_repetition_cnt <= cfg_reps;
              wr_ptr_q           <= '0;
              smp_cnt_q          <= '0;
              rec_cnt            <= '0;
              overflow           <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
              timeout            <= 1'b0;
              tmo_lim_q          <= cfg_timeout;
`endif
              if (cfg_reps == 24'd0) begin
                done <= 1'b1;
              end else begin
                done    <= 1'b0;
                busy    <= 1'b1;
                state_q <= StArm;
              end
            end
          end
          StArm: begin
            if (fsm_state == 2'd0) begin
              sniff_trig <= 1'b1;
              state_q    <= StRun;
`ifdef ACQ_TIMEOUT_EN
              tmo_cnt_q  <= '0;
`endif
            end
          end
          StRun: begin
            if (fsm_we) begin
              // Past the last address writes are dropped but counting carries on.
              if (!overflow) begin
                buf_we   <= 1'b1;
                buf_addr <= wr_ptr_q;
                buf_data <= fsm_data;
                if (wr_ptr_q == '1) overflow <= 1'b1;
                else                wr_ptr_q <= wr_ptr_q + PtrOne;
              end
              if (smp_cnt_q == max_sample_cnt) begin
                smp_cnt_q <= '0;
                rec_cnt   <= rec_cnt + 24'd1;
                if (rec_last) state_q <= StFinish;
              end else begin
                smp_cnt_q <= smp_cnt_q + 24'd1;
              end
            end
`ifdef ACQ_TIMEOUT_EN
            tmo_cnt_q <= fsm_we ? '0 : tmo_cnt_q + TmoOne;
            if (tmo_fire) begin
              timeout <= 1'b1;
              state_q <= StIdle;
              busy    <= 1'b0;
              done    <= 1'b0;
            end
`endif
          end
          StFinish: begin
            if (fsm_state == 2'd0) begin
              state_q <= StIdle;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer (ADDR_W=4): normal run, zero reps, overflow, abort/re-arm
// and idle timeout (outcome depends on ACQ_TIMEOUT_EN).
module tb_acq_sequencer;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [23:0]   cfg_samples, cfg_reps;
  logic [31:0]   cfg_timeout;
  logic [1:0]    fsm_state;
  logic          fsm_we;
  logic [13:0]   fsm_data;
  logic          sniff_trig, buf_we, busy, done, overflow, timeout;
  logic [23:0]   max_sample_cnt, max_repetition_cnt, rec_cnt;
  logic [AW-1:0] buf_addr;
  logic [13:0]   buf_data;

  int n_checks = 0;
  int n_err    = 0;
  int sniff_n  = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [13:0]   wr_data_q[$];

  always #5 clk = ~clk;

  acq_sequencer #(.ADDR_W(AW), .TMO_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_samples(cfg_samples), .cfg_reps(cfg_reps), .cfg_timeout(cfg_timeout),
    .fsm_state(fsm_state), .fsm_we(fsm_we), .fsm_data(fsm_data),
    .sniff_trig(sniff_trig), .max_sample_cnt(max_sample_cnt),
    .max_repetition_cnt(max_repetition_cnt), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_data(buf_data), .busy(busy), .done(done), .overflow(overflow), .timeout(timeout),
    .rec_cnt(rec_cnt)
  );

  always @(negedge clk) begin
    if (buf_we) begin
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_data);
    end
    if (sniff_trig) sniff_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    sniff_n = 0;
  endtask

  task automatic burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fsm_we   = 1'b1;
      fsm_data = 14'(base + i);
      cyc(1);
    end
    fsm_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_samples = '0; cfg_reps = '0; cfg_timeout = '0;
    fsm_state = 2'd0; fsm_we = 1'b0; fsm_data = '0;
    cyc(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_max_smp", {8'd0, max_sample_cnt}, 32'd0);
    check("rst_rec_cnt", {8'd0, rec_cnt}, 32'd0);
    check("rst_buf_we", {31'd0, buf_we}, 32'd0);
    rst = 1'b0;
    cyc(1);

    // Normal run: 2 records of 4 samples
    cfg_samples = 24'd3; cfg_reps = 24'd2; clear_mon();
    start = 1'b1; cyc(1); start = 1'b0;
    check("t1_busy_arm", {31'd0, busy}, 32'd1);
    check("t1_max_smp", {8'd0, max_sample_cnt}, 32'd3);
    check("t1_max_rep", {8'd0, max_repetition_cnt}, 32'd2);
    cyc(1);
    check("t1_sniff", {31'd0, sniff_trig}, 32'd1);
    fsm_state = 2'd1;
    burst(8, 256);
    check("t1_last_we", {31'd0, buf_we}, 32'd1);
    check("t1_last_addr", {28'd0, buf_addr}, 32'd7);
    check("t1_rec_cnt", {8'd0, rec_cnt}, 32'd2);
    cyc(2);
    check("t1_done_wait", {31'd0, done}, 32'd0);
    check("t1_busy_fin", {31'd0, busy}, 32'd1);
    fsm_state = 2'd0;
    cyc(1);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    cyc(1);
    check("t1_nwr", 32'(wr_addr_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      check("t1_addr", {28'd0, wr_addr_q[i]}, 32'(i));
      check("t1_data", {18'd0, wr_data_q[i]}, 32'(256 + i));
    end
    check("t1_nsniff", 32'(sniff_n), 32'd1);

    // Zero reps: done at once, no arm
    cfg_reps = 24'd0; clear_mon();
    start = 1'b1; cyc(1); start = 1'b0;
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    cyc(3);
    check("t2_nsniff", 32'(sniff_n), 32'd0);
    check("t2_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Overflow: 20 samples into a 16-entry buffer
    cfg_samples = 24'd9; cfg_reps = 24'd2; clear_mon();
    start = 1'b1; cyc(1); start = 1'b0;
    check("t3_done_clr", {31'd0, done}, 32'd0);
    cyc(1);
    check("t3_sniff", {31'd0, sniff_trig}, 32'd1);
    fsm_state = 2'd1;
    burst(20, 512);
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    check("t3_rec_cnt", {8'd0, rec_cnt}, 32'd2);
    check("t3_we_drop", {31'd0, buf_we}, 32'd0);
    fsm_state = 2'd0;
    cyc(1);
    check("t3_done", {31'd0, done}, 32'd1);
    cyc(1);
    check("t3_nwr", 32'(wr_addr_q.size()), 32'd16);
    if (wr_addr_q.size() == 16) begin
      check("t3_addr15", {28'd0, wr_addr_q[15]}, 32'd15);
      check("t3_data15", {18'd0, wr_data_q[15]}, 32'(512 + 15));
      check("t3_data0", {18'd0, wr_data_q[0]}, 32'd512);
    end

    // Abort mid record 2, then re-arm held off by a busy FSM
    cfg_samples = 24'd3; cfg_reps = 24'd3; clear_mon();
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    fsm_state = 2'd1;
    burst(6, 768);
    fsm_we = 1'b1; abort = 1'b1;
    cyc(1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_we", {31'd0, buf_we}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);
    check("t4_rec_cnt", {8'd0, rec_cnt}, 32'd1);
    abort = 1'b0;
    cyc(3);
    fsm_we = 1'b0;
    check("t4_nwr", 32'(wr_addr_q.size()), 32'd6);
    start = 1'b1; cyc(1); start = 1'b0;
    check("t4_rearm_busy", {31'd0, busy}, 32'd1);
    cyc(3);
    check("t4_hold_sniff", {31'd0, sniff_trig}, 32'd0);
    check("t4_hold_nsniff", 32'(sniff_n), 32'd1);
    fsm_state = 2'd0;
    cyc(1);
    check("t4_sniff", {31'd0, sniff_trig}, 32'd1);
    abort = 1'b1; cyc(1); abort = 1'b0;

    // Idle timeout after RUN entry; also a start edge in RUN is ignored
    cfg_samples = 24'd3; cfg_reps = 24'd1; cfg_timeout = 32'd100; clear_mon();
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    check("t5_sniff", {31'd0, sniff_trig}, 32'd1);
    cyc(8);
    start = 1'b1; cyc(1); start = 1'b0;
    check("t5_run_start_busy", {31'd0, busy}, 32'd1);
    check("t5_run_start_sniff", {31'd0, sniff_trig}, 32'd0);
    cyc(90);
    check("t5_busy_99", {31'd0, busy}, 32'd1);
    cyc(1);
`ifdef ACQ_TIMEOUT_EN
    check("t5_busy_100", {31'd0, busy}, 32'd0);
    check("t5_timeout", {31'd0, timeout}, 32'd1);
    check("t5_done", {31'd0, done}, 32'd0);
`else
    check("t5_busy_100", {31'd0, busy}, 32'd1);
    check("t5_timeout", {31'd0, timeout}, 32'd0);
`endif
    abort = 1'b1; cyc(1); abort = 1'b0;
    cyc(1);
    check("t5_nsniff", 32'(sniff_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
